// File: rtl/ysyx_lsu_pkg.sv
// ysyx_lsu shared definitions: select encodings, FSM states, byte masks.
// Imported by ysyx_lsu and ysyx_lsu_align.
package ysyx_lsu_pkg;

  localparam logic [2:0] RD_NONE = 3'b000;
  localparam logic [2:0] RD_LB   = 3'b001;
  localparam logic [2:0] RD_LBU  = 3'b010;
  localparam logic [2:0] RD_LH   = 3'b011;
  localparam logic [2:0] RD_LHU  = 3'b100;
  localparam logic [2:0] RD_LW   = 3'b101;

  localparam logic [1:0] WR_NONE = 2'b00;
  localparam logic [1:0] WR_SB   = 2'b01;
  localparam logic [1:0] WR_SH   = 2'b10;
  localparam logic [1:0] WR_SW   = 2'b11;

  localparam logic [3:0] MASK_B   = 4'b0001;
  localparam logic [3:0] MASK_HLO = 4'b0011;
  localparam logic [3:0] MASK_HHI = 4'b1100;
  localparam logic [3:0] MASK_W   = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } lsu_state_e;

endpackage

// File: rtl/ysyx_lsu_align.sv
// ysyx_lsu byte-lane logic: store replication/strobes, load extract and
// extension, misalignment and illegal-select detection. Purely combinational.
module ysyx_lsu_align
  import ysyx_lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [2:0]  rd_sel,
  input  logic [1:0]  wr_sel,
  input  logic [31:0] rsp_rdata,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_wmask,
  output logic [31:0] ld_data,
  output logic        misaligned,
  output logic        illegal
);

  logic [31:0] shifted;
  logic        is_half;
  logic        is_word;

  assign shifted = rsp_rdata >> {addr_lo, 3'b000};

  // replicate store data across lanes and pick the byte strobes
  always_comb begin
    st_wdata = '0;
    st_wmask = '0;
    unique case (1'b1)
      (wr_sel == WR_SB): begin
        st_wdata = {4{wdata[7:0]}};
        st_wmask = MASK_B << addr_lo;
      end
      (wr_sel == WR_SH): begin
        st_wdata = {2{wdata[15:0]}};
        st_wmask = addr_lo[1] ? MASK_HHI : MASK_HLO;
      end
      (wr_sel == WR_SW): begin
        st_wdata = wdata;
        st_wmask = MASK_W;
      end
      default: ;
    endcase
  end

  // pull the addressed bytes down to bit 0 and extend them
  always_comb begin
    ld_data = '0;
    unique case (1'b1)
      (rd_sel == RD_LB):  ld_data = {{24{shifted[7]}}, shifted[7:0]};
      (rd_sel == RD_LBU): ld_data = {24'b0, shifted[7:0]};
      (rd_sel == RD_LH):  ld_data = {{16{shifted[15]}}, shifted[15:0]};
      (rd_sel == RD_LHU): ld_data = {16'b0, shifted[15:0]};
      (rd_sel == RD_LW):  ld_data = shifted;
      default: ;
    endcase
  end

  assign is_half = (rd_sel == RD_LH) || (rd_sel == RD_LHU) ||
                   (wr_sel == WR_SH);
  assign is_word = (rd_sel == RD_LW) || (wr_sel == WR_SW);

  assign misaligned = (is_half && addr_lo[0]) ||
                      (is_word && (addr_lo != 2'b00));

  assign illegal = ((rd_sel != RD_NONE) && (wr_sel != WR_NONE)) ||
                   (rd_sel > RD_LW);

endmodule

// File: rtl/ysyx_lsu.sv
// ysyx_lsu: EXU-to-data-bus load/store unit with valid/ready on both sides.
// Optional WAIT timeout when YSYX_LSU_TIMEOUT_EN is defined.
module ysyx_lsu
  import ysyx_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_rd_sel,
  input  logic [1:0]  req_wr_sel,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic        resp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wmask,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata
);

  lsu_state_e  state;
  logic [31:0] addr_q;
  logic [2:0]  rd_sel_q;
  logic [1:0]  wr_sel_q;
  logic [4:0]  rd_q;
  logic [31:0] wdata_q;
  logic [3:0]  wmask_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        idle;
  logic [1:0]  al_addr;
  logic [2:0]  al_rd_sel;
  logic [1:0]  al_wr_sel;
  logic [31:0] al_wdata;
  logic [3:0]  al_wmask;
  logic [31:0] al_ld;
  logic        al_mis;
  logic        al_ill;
  logic        noop;
  logic        tmo_hit;

  assign idle = (state == S_IDLE);

  // IDLE classifies the incoming op; later states work on captured values
  assign al_addr   = idle ? req_addr[1:0] : addr_q[1:0];
  assign al_rd_sel = idle ? req_rd_sel    : rd_sel_q;
  assign al_wr_sel = idle ? req_wr_sel    : wr_sel_q;

  ysyx_lsu_align u_align (
    .addr_lo    (al_addr),
    .wdata      (req_wdata),
    .rd_sel     (al_rd_sel),
    .wr_sel     (al_wr_sel),
    .rsp_rdata  (mem_rsp_rdata),
    .st_wdata   (al_wdata),
    .st_wmask   (al_wmask),
    .ld_data    (al_ld),
    .misaligned (al_mis),
    .illegal    (al_ill)
  );

  assign noop = (req_rd_sel == RD_NONE) && (req_wr_sel == WR_NONE);

`ifdef YSYX_LSU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_cnt;

  // count WAIT cycles; held at zero outside WAIT so entry starts clean
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state != S_WAIT) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign tmo_hit = (state == S_WAIT) && (tmo_cnt == TMO_LAST);
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign tmo_hit = 1'b0;
`endif

  // request/response sequencing and capture of the operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      rd_sel_q <= '0;
      wr_sel_q <= '0;
      rd_q     <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_q   <= req_addr;
            rd_sel_q <= req_rd_sel;
            wr_sel_q <= req_wr_sel;
            rd_q     <= req_rd;
            wdata_q  <= al_wdata;
            wmask_q  <= al_wmask;
            rdata_q  <= '0;
            err_q    <= al_ill || al_mis;
            if (al_ill || al_mis || noop) begin
              state <= S_RESP;
            end else begin
              state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rsp_valid) begin
            rdata_q <= al_ld;
            state   <= S_RESP;
          end else if (tmo_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state   <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready     = idle;
  assign mem_req_valid = (state == S_REQ);
  assign resp_valid    = (state == S_RESP);
  assign mem_req_addr  = {addr_q[31:2], 2'b00};
  assign mem_req_wen   = (wr_sel_q != WR_NONE);
  assign mem_req_wdata = wdata_q;
  assign mem_req_wmask = wmask_q;
  assign resp_rdata    = rdata_q;
  assign resp_err      = err_q;
  assign resp_rd       = rd_q;

endmodule

// File: tb/tb_ysyx_lsu.sv
// ysyx_lsu bench: directed cases plus random ops against a byte-array model.
// Timeout case expects TIMEOUT_CYCLES=4 when YSYX_LSU_TIMEOUT_EN is defined.
module tb_ysyx_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_rd_sel;
  logic [1:0]  req_wr_sel;
  logic [4:0]  req_rd;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        resp_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;

  int errors = 0;
  int checks = 0;

  logic [7:0]  rbyte [0:63];
  logic [31:0] bmem  [0:15];

  ysyx_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_rd_sel    (req_rd_sel),
    .req_wr_sel    (req_wr_sel),
    .req_rd        (req_rd),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_rdata    (resp_rdata),
    .resp_rd       (resp_rd),
    .resp_err      (resp_err),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wen   (mem_req_wen),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_wmask (mem_req_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int sz(input logic [2:0] rs, input logic [1:0] ws);
    if (rs == 3'd3 || rs == 3'd4 || ws == 2'd2) return 2;
    if (rs == 3'd5 || ws == 2'd3) return 4;
    return 1;
  endfunction

  function automatic logic [31:0] ref_load(input logic [5:0] off,
                                           input logic [2:0] rs);
    logic [31:0] v;
    int n;
    n = sz(rs, 2'd0);
    v = '0;
    for (int i = 0; i < n; i++)
      v = v | (32'(rbyte[6'(off + 6'(i))]) << (8 * i));
    if ((rs == 3'd1 || rs == 3'd3) && v[8*n-1])
      v = v | ~((32'h1 << (8 * n)) - 32'h1);
    return v;
  endfunction

  task automatic set_word(input int w, input logic [31:0] v);
    bmem[w] = v;
    for (int i = 0; i < 4; i++) rbyte[4*w+i] = v[8*i+:8];
  endtask

  task automatic scramble_req;
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_rd_sel = 3'($urandom);
    req_wr_sel = 2'($urandom);
    req_rd     = 5'($urandom);
  endtask

  task automatic op(input logic [5:0] off, input logic [31:0] d,
                    input logic [2:0] rs, input logic [1:0] ws,
                    input int rqh, input int rsh_in, input int rph,
                    input bit hs_rsp);
    logic [31:0] a, exp_rd, exp_wd, bd;
    logic [3:0]  exp_m, bm;
    logic [4:0]  rd;
    int n, o, rsh, w;
    bit err, bus;
    a   = 32'h8000_0000 | 32'(off);
    rd  = 5'($urandom);
    n   = sz(rs, ws);
    o   = int'(off[1:0]);
    w   = int'(off[5:2]);
    rsh = (hs_rsp && rsh_in == 0) ? 1 : rsh_in;
    err = (rs != 0 && ws != 0) || rs > 3'd5 || (o % n != 0);
    bus = !err && (rs != 0 || ws != 0);
    exp_m  = '0;
    exp_wd = '0;
    bm = '0;
    bd = '0;
    for (int i = 0; i < 4; i++) begin
      if (i >= o && i < o + n) exp_m[i] = 1'b1;
      exp_wd[8*i+:8] = d[8*(i%n)+:8];
    end
    exp_rd = (bus && rs != 0) ? ref_load(off, rs) : 32'h0;

    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_addr   = a;
    req_wdata  = d;
    req_rd_sel = rs;
    req_wr_sel = ws;
    req_rd     = rd;
    tick();
    req_valid = 1'b0;
    scramble_req();
    chk("req_ready_busy", 32'(req_ready), 32'd0);

    if (!bus) begin
      chk("no_bus_traffic", 32'(mem_req_valid), 32'd0);
    end else begin
      for (int i = 0; i <= rqh; i++) begin
        chk("mem_req_valid", 32'(mem_req_valid), 32'd1);
        chk("mem_req_addr", mem_req_addr, {a[31:2], 2'b00});
        chk("mem_req_wen", 32'(mem_req_wen), 32'(ws != 0));
        if (ws != 0) begin
          chk("mem_req_wmask", 32'(mem_req_wmask), 32'(exp_m));
          chk("mem_req_wdata", mem_req_wdata, exp_wd);
        end
        chk("resp_valid_req", 32'(resp_valid), 32'd0);
        chk("req_ready_req", 32'(req_ready), 32'd0);
        if (i == rqh) begin
          bm = mem_req_wmask;
          bd = mem_req_wdata;
          mem_req_ready = 1'b1;
          mem_rsp_valid = hs_rsp;
          mem_rsp_rdata = 32'h5A5A_5A5A;
        end
        tick();
      end
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      if (ws != 0) begin
        for (int i = 0; i < 4; i++)
          if (bm[i]) bmem[w][8*i+:8] = bd[8*i+:8];
        for (int i = 0; i < n; i++)
          rbyte[6'(off + 6'(i))] = d[8*i+:8];
      end
      for (int j = 0; j < rsh; j++) begin
        chk("wait_req_low", 32'(mem_req_valid), 32'd0);
        chk("wait_resp_low", 32'(resp_valid), 32'd0);
        tick();
      end
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = (ws != 0) ? $urandom : bmem[w];
      tick();
      mem_rsp_valid = 1'b0;
      mem_rsp_rdata = $urandom;
    end

    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("resp_err", 32'(resp_err), 32'(err));
    chk("resp_rdata", resp_rdata, exp_rd);
    chk("resp_rd", 32'(resp_rd), 32'(rd));
    for (int k = 0; k < rph; k++) begin
      tick();
      chk("resp_hold_valid", 32'(resp_valid), 32'd1);
      chk("resp_hold_rdata", resp_rdata, exp_rd);
      chk("resp_hold_err", 32'(resp_err), 32'(err));
      chk("resp_hold_busy", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("resp_done", 32'(resp_valid), 32'd0);
    chk("back_idle", 32'(req_ready), 32'd1);
  endtask

  task automatic lw_to_wait(input logic [5:0] off);
    req_valid  = 1'b1;
    req_addr   = 32'h8000_0000 | 32'({off[5:2], 2'b00});
    req_wdata  = '0;
    req_rd_sel = 3'b101;
    req_wr_sel = 2'b00;
    req_rd     = 5'd7;
    tick();
    req_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("wait_entered", 32'(mem_req_valid), 32'd0);
  endtask

  initial begin
    logic [5:0] off;
    logic [2:0] rs;
    logic [1:0] ws;
    int kind;

    rst_n = 1'b0;
    req_valid = 1'b0;
    resp_ready = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    scramble_req();
    for (int i = 0; i < 16; i++) set_word(i, $urandom);
    set_word(0, 32'h80FF_0000);

    repeat (3) tick();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mem_req_addr", mem_req_addr, 32'd0);
    chk("rst_mem_req_wen", 32'(mem_req_wen), 32'd0);
    chk("rst_mem_req_wmask", 32'(mem_req_wmask), 32'd0);
    chk("rst_mem_req_wdata", mem_req_wdata, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rd", 32'(resp_rd), 32'd0);
    rst_n = 1'b1;
    tick();

    op(6'd4, 32'hDEAD_BEEF, 3'b000, 2'b11, 0, 0, 0, 1'b0);
    op(6'd3, 32'h0, 3'b001, 2'b00, 0, 0, 0, 1'b0);
    chk("lb_sign_const", resp_rdata, 32'hFFFF_FF80);
    op(6'd3, 32'h0, 3'b010, 2'b00, 0, 0, 0, 1'b0);
    op(6'd2, 32'h1234_ABCD, 3'b000, 2'b10, 0, 0, 0, 1'b0);
    op(6'd1, 32'h0, 3'b011, 2'b00, 0, 0, 0, 1'b0);
    op(6'd4, 32'h0, 3'b101, 2'b00, 3, 1, 2, 1'b0);
    op(6'd8, 32'h0, 3'b101, 2'b00, 0, 2, 0, 1'b1);
    op(6'd5, 32'h0, 3'b110, 2'b00, 0, 0, 1, 1'b0);
    op(6'd0, 32'h0, 3'b001, 2'b01, 0, 0, 0, 1'b0);
    op(6'd9, 32'h0, 3'b000, 2'b00, 0, 0, 0, 1'b0);
    op(6'd6, 32'h0, 3'b000, 2'b11, 0, 0, 0, 1'b0);

`ifdef YSYX_LSU_TIMEOUT_EN
    lw_to_wait(6'd12);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("tmo_pending", 32'(resp_valid), 32'd0);
    end
    tick();
    chk("tmo_resp_valid", 32'(resp_valid), 32'd1);
    chk("tmo_resp_err", 32'(resp_err), 32'd1);
    chk("tmo_resp_rdata", resp_rdata, 32'd0);
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'hFFFF_FFFF;
    tick();
    mem_rsp_valid = 1'b0;
    chk("late_rsp_err", 32'(resp_err), 32'd1);
    chk("late_rsp_rdata", resp_rdata, 32'd0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("tmo_back_idle", 32'(req_ready), 32'd1);
    lw_to_wait(6'd16);
    tick();
    tick();
`else
    lw_to_wait(6'd12);
    repeat (100) tick();
    chk("still_wait_resp", 32'(resp_valid), 32'd0);
    chk("still_wait_busy", 32'(req_ready), 32'd0);
    chk("still_wait_req", 32'(mem_req_valid), 32'd0);
`endif

    rst_n = 1'b0;
    #1;
    chk("arst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("arst_resp_valid", 32'(resp_valid), 32'd0);
    chk("arst_req_ready", 32'(req_ready), 32'd1);
    chk("arst_resp_rdata", resp_rdata, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    op(6'd4, 32'h0, 3'b101, 2'b00, 0, 0, 0, 1'b0);

    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 19);
      rs = 3'b000;
      ws = 2'b00;
      if (kind == 0) rs = 3'($urandom_range(6, 7));
      else if (kind == 1) begin
        rs = 3'($urandom_range(1, 5));
        ws = 2'($urandom_range(1, 3));
      end else if (kind <= 10) rs = 3'($urandom_range(1, 5));
      else if (kind <= 19 && kind > 2) ws = 2'($urandom_range(1, 3));
      off = 6'($urandom);
      if ($urandom_range(0, 3) != 0)
        off = off & ~6'(sz(rs, ws) - 1);
      op(off, $urandom, rs, ws, $urandom_range(0, 3),
         $urandom_range(0, 3), $urandom_range(0, 2),
         1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_lsu.md
# ysyx_lsu

Load/store unit between the execute stage and the data-memory bus. Takes one memory operation per handshake (address from the ALU result, store data from rs2, load/store selects from decode), issues a single word-aligned bus transaction with byte-lane strobes, and returns load data aligned and sign- or zero-extended toward register writeback. It replaces direct DPI memory calls in the execute stage with a stall-capable valid/ready path.

## Interface
- `TIMEOUT_CYCLES`, 255: WAIT-state cycle limit; used only with `YSYX_LSU_TIMEOUT_EN`.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: EXU presents an operation.
- `req_ready` out 1: LSU accepts; high only in IDLE.
- `req_addr` in 32: byte address (ALU result).
- `req_wdata` in 32: store data (rs2).
- `req_rd_sel` in 3: 000 none, 001 lb, 010 lbu, 011 lh, 100 lhu, 101 lw; others illegal.
- `req_wr_sel` in 2: 00 none, 01 sb, 10 sh, 11 sw.
- `req_rd` in 5: destination register index, passed through.
- `resp_valid` out 1 / `resp_ready` in 1: result handshake.
- `resp_rdata` out 32: extended load data; 0 for stores/no-op/error.
- `resp_rd` out 5: captured `req_rd`.
- `resp_err` out 1: misaligned, illegal select, or timeout.
- `mem_req_valid` out 1 / `mem_req_ready` in 1: bus request handshake.
- `mem_req_addr` out 32: `{req_addr[31:2],2'b00}`.
- `mem_req_wen` out 1: 1 for store.
- `mem_req_wdata` out 32: lane-replicated store data.
- `mem_req_wmask` out 4: byte strobes.
- `mem_rsp_valid` in 1 / `mem_rsp_rdata` in 32: bus response (read data or write ack); always accepted.

## Operation
- FSM: IDLE, REQ, WAIT, RESP. Reset -> IDLE; all outputs 0 except `req_ready`=1; captured registers 0.
- IDLE: on `req_valid&&req_ready` capture addr, wdata, selects, rd. Classify:
  - both selects nonzero, or rd_sel 110/111 -> error -> RESP, `resp_err`=1.
  - misaligned (lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0) -> RESP, `resp_err`=1, no bus traffic.
  - both selects zero -> RESP, rdata 0, err 0, no bus traffic.
  - else -> REQ.
- REQ: `mem_req_valid`=1, payload stable until `mem_req_ready`; then WAIT.
- WAIT: on `mem_rsp_valid` register extracted data -> RESP.
- RESP: `resp_valid`=1, outputs stable until `resp_ready`; then IDLE.
- Store lanes: sb -> wdata `{4{b}}`, mask `4'b0001<<addr[1:0]`; sh -> `{2{h}}`, mask `addr[1]?1100:0011`; sw -> wdata as is, mask 1111.
- Load extract: shift `mem_rsp_rdata` right by `addr[1:0]*8`; lb/lh sign-extend bit 7/15, lbu/lhu zero-extend, lw unchanged.
- Stores complete on `mem_rsp_valid` (ack); response data ignored, rdata 0.
- `rst_n` asserted in any state: immediate return to IDLE, in-flight bus transaction abandoned, outputs to reset values.

## Timing
- Accept at edge T; `mem_req_valid` high in cycle T+1.
- `mem_rsp_valid` is sampled only from the cycle after the request handshake; a response in the handshake cycle is ignored.
- Minimum bus op: request accepted T+1, response T+2, `resp_valid` T+3.
- Error/no-op ops: `resp_valid` in T+1.
- One outstanding operation; `req_ready`=0 from T+1 until return to IDLE.
- `resp_valid&&resp_ready` in RESP -> IDLE next cycle; new request accepted no earlier than the following edge.

## Configuration
- `YSYX_LSU_TIMEOUT_EN` defined: counter clears on entry to WAIT and increments each WAIT cycle. When it reaches `TIMEOUT_CYCLES` with no response -> RESP, `resp_err`=1, rdata 0. A late response arriving afterward is dropped.
- Not defined: no counter; WAIT persists until a response arrives.

## Structure
- Package `ysyx_lsu_pkg`: rd_sel/wr_sel encoding constants, FSM state typedef, byte-mask constants.
- Sub-module `ysyx_lsu_align`: combinational store lane/mask generation, load extract/extend, misalignment detect.
- Top module holds the FSM, capture registers, and timeout counter.

## Test plan
- sw addr 0x8000_0004, data 0xDEADBEEF, bus ready/ack immediate -> mem addr 0x8000_0004, mask 1111, `resp_valid` at T+3, err 0.
- lb addr 0x8000_0003, bus rdata 0x80FF_0000 -> `resp_rdata` 0xFFFF_FF80; lbu same -> 0x0000_0080.
- sh addr 0x8000_0002, data 0x1234_ABCD -> wdata 0xABCD_ABCD, mask 1100; lh addr 0x8000_0001 -> no `mem_req_valid`, `resp_err`=1 at T+1.
- `mem_req_ready` low 3 cycles, then `resp_ready` low 2 cycles -> payload and resp outputs held stable; `req_ready` stays 0 throughout.
- With `YSYX_LSU_TIMEOUT_EN`, TIMEOUT_CYCLES=4, no response -> `resp_err`=1 after 4 WAIT cycles; without the macro, still in WAIT after 100 cycles.
- `rst_n` pulsed low during WAIT -> `mem_req_valid`/`resp_valid` 0 immediately, `req_ready`=1; next lw returns correct data.
